// File: rtl/lsu_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_bridge
// Purpose  : Load/store unit placed after the execute stage of a single-cycle
//            core. Turns each load/store into one req/gnt/rvalid transaction
//            on a word-organised memory bus and stalls the core until the
//            access completes.
//            - Stores: byte enables from size/offset, lane-replicated data.
//            - Loads : addressed lane extracted, sign- or zero-extended.
//            - Misaligned or illegal-size accesses finish with access_fault
//              and no bus transaction.
// Ports    : clk, reset (sync, active-high)
//            mem_read, mem_write, funct3, addr, write_data  (core side in)
//            read_data, stall, access_fault, bus_err         (core side out)
//            bus_req, bus_we, bus_addr, bus_be, bus_wdata    (bus out)
//            bus_gnt, bus_rvalid, bus_rdata                  (bus in)
// Options  : LSU_BUS_TIMEOUT_EN - when defined, a REQ/WAIT cycle counter
//            aborts the access after TIMEOUT_CYCLES and pulses bus_err.
//            When undefined, bus_err is constant 0 and the LSU waits forever.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_bridge #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    output logic              stall,
    output logic              access_fault,
    output logic              bus_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-3:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [31:0]       bus_rdata
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_WAIT = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    localparam logic [1:0] c_SZ_BYTE = 2'b00;
    localparam logic [1:0] c_SZ_HALF = 2'b01;
    localparam logic [1:0] c_SZ_WORD = 2'b10;

    logic [1:0]        r_state;
    logic [31:0]       r_read_data;
    logic              r_access_fault;
    logic              r_bus_req;
    logic              r_bus_we;
    logic [ADDR_W-3:0] r_bus_addr;
    logic [3:0]        r_bus_be;
    logic [31:0]       r_bus_wdata;
    // Load shaping info captured at issue, so extraction does not depend on
    // the core keeping addr/funct3 stable.
    logic [1:0]        r_off;
    logic [1:0]        r_size;
    logic              r_uns;
    logic              r_both;

    logic              w_act;
    logic              w_bad;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [31:0]       w_shifted;
    logic [31:0]       w_load_val;
    logic              w_tmo_fire;

    assign w_act = mem_read | mem_write;
    assign stall = w_act & (r_state != c_ST_DONE);

    assign w_bad = (funct3[1:0] == 2'b11)
                 | ((funct3[1:0] == c_SZ_HALF) & addr[0])
                 | ((funct3[1:0] == c_SZ_WORD) & (addr[1:0] != 2'b00));

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = write_data;
        case (funct3[1:0])
            c_SZ_BYTE: begin
                w_be    = 4'b0001 << addr[1:0];
                w_wdata = {4{write_data[7:0]}};
            end
            c_SZ_HALF: begin
                w_be    = 4'b0011 << addr[1:0];
                w_wdata = {2{write_data[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = write_data;
            end
        endcase
    end

    assign w_shifted = bus_rdata >> {r_off, 3'b000};

    always_comb begin
        w_load_val = w_shifted;
        case (r_size)
            c_SZ_BYTE: w_load_val = {{24{~r_uns & w_shifted[7]}}, w_shifted[7:0]};
            c_SZ_HALF: w_load_val = {{16{~r_uns & w_shifted[15]}}, w_shifted[15:0]};
            default:   w_load_val = w_shifted;
        endcase
    end

`ifdef LSU_BUS_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_CNT_W-1:0] r_tmo_cnt;
    logic               r_bus_err;
    logic               w_tmo_hit;

    // The count is 0 in the first REQ cycle, so the limit is met during the
    // TIMEOUT_CYCLES-th cycle spent waiting.
    assign w_tmo_hit  = (32'(r_tmo_cnt) >= 32'(TIMEOUT_CYCLES - 1));
    assign w_tmo_fire = w_tmo_hit
                      & (((r_state == c_ST_REQ)  & ~bus_gnt)
                       | ((r_state == c_ST_WAIT) & ~bus_rvalid));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmo_cnt <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= w_tmo_fire;
            if ((r_state == c_ST_REQ) || (r_state == c_ST_WAIT)) begin
                if (32'(r_tmo_cnt) < 32'(TIMEOUT_CYCLES))
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end else begin
                r_tmo_cnt <= '0;
            end
        end
    end

    assign bus_err = r_bus_err;
`else
    assign w_tmo_fire = 1'b0;
    assign bus_err    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= c_ST_IDLE;
            r_read_data    <= '0;
            r_access_fault <= 1'b0;
            r_bus_req      <= 1'b0;
            r_bus_we       <= 1'b0;
            r_bus_addr     <= '0;
            r_bus_be       <= '0;
            r_bus_wdata    <= '0;
            r_off          <= '0;
            r_size         <= '0;
            r_uns          <= 1'b0;
            r_both         <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_act) begin
                        if (w_bad) begin
                            r_state        <= c_ST_DONE;
                            r_access_fault <= 1'b1;
                            r_read_data    <= '0;
                        end else begin
                            r_state     <= c_ST_REQ;
                            r_bus_req   <= 1'b1;
                            r_bus_we    <= mem_write;
                            r_bus_addr  <= addr[ADDR_W-1:2];
                            r_bus_be    <= w_be;
                            r_bus_wdata <= w_wdata;
                            r_off       <= addr[1:0];
                            r_size      <= funct3[1:0];
                            r_uns       <= funct3[2];
                            r_both      <= mem_read & mem_write;
                        end
                    end
                end
                c_ST_REQ: begin
                    if (bus_gnt) begin
                        r_bus_req <= 1'b0;
                        if (r_bus_we) begin
                            r_state <= c_ST_DONE;
                            // Simultaneous read+write: the write wins and
                            // the load result is forced to zero.
                            if (r_both)
                                r_read_data <= '0;
                        end else begin
                            r_state <= c_ST_WAIT;
                        end
                    end else if (w_tmo_fire) begin
                        r_bus_req   <= 1'b0;
                        r_state     <= c_ST_DONE;
                        r_read_data <= '0;
                    end
                end
                c_ST_WAIT: begin
                    if (bus_rvalid) begin
                        r_read_data <= w_load_val;
                        r_state     <= c_ST_DONE;
                    end else if (w_tmo_fire) begin
                        r_read_data <= '0;
                        r_state     <= c_ST_DONE;
                    end
                end
                default: begin
                    // DONE lasts one cycle regardless of the request inputs.
                    r_state        <= c_ST_IDLE;
                    r_access_fault <= 1'b0;
                end
            endcase
        end
    end

    assign read_data    = r_read_data;
    assign access_fault = r_access_fault;
    assign bus_req      = r_bus_req;
    assign bus_we       = r_bus_we;
    assign bus_addr     = r_bus_addr;
    assign bus_be       = r_bus_be;
    assign bus_wdata    = r_bus_wdata;

endmodule
`default_nettype wire

// File: doc/lsu_mem_bridge.md
Name: lsu_mem_bridge

Overview:
Load/store unit sitting directly downstream of the single-cycle core's execute stage. It takes the ALU address, store data and memory controls, and replaces the ideal single-cycle data memory with a req/gnt/rvalid bus to a word-organised memory.
- Stores: generates byte enables and replicates the write lanes.
- Loads: extracts the addressed lane and sign- or zero-extends it.
- Stalls the core until each access completes.

Parameters:
- ADDR_W, 32, byte-address width from the core.
- TIMEOUT_CYCLES, 64, bus timeout limit in cycles; used only when the optional feature is compiled in.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- mem_read  in  1  load request from decode, held until stall drops
- mem_write  in  1  store request from decode, held until stall drops
- funct3  in  3  [1:0] size (00 byte, 01 half, 10 word, 11 illegal); [2] unsigned load
- addr  in  ADDR_W  byte address (ALU result)
- write_data  in  32  store data (rs2 value)
- read_data  out  32  extended load result; valid in DONE
- stall  out  1  freeze PC and register write
- access_fault  out  1  one-cycle pulse in DONE on a misaligned or illegal-size access
- bus_err  out  1  one-cycle pulse in DONE on a bus timeout
- bus_req  out  1  bus request
- bus_we  out  1  1 = write
- bus_addr  out  ADDR_W-2  word address
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_gnt  in  1  request accepted this cycle
- bus_rvalid  in  1  read data valid
- bus_rdata  in  32  read word

Behaviour:
- Clocking and reset: single clock clk. Reset is synchronous and active-high on reset.
- Reset state: state=IDLE. read_data, bus_req, bus_we, bus_addr, bus_be, bus_wdata, access_fault and bus_err are all 0.
- Active request: act = mem_read | mem_write. When both are high, the write wins and read_data=0.
- Stall: stall = act & (state != DONE), combinational.
- Alignment and size rules:
  - Misaligned means a half access with addr[0]=1, or a word access with addr[1:0]!=0.
  - size=11 is illegal.
  - Either case goes IDLE->DONE with no bus transaction; access_fault=1 in DONE and read_data=0.
- IDLE, on act with a legal access:
  - Register bus_addr=addr[ADDR_W-1:2] and bus_we=mem_write.
  - Byte enables: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
  - Write data: byte {4{wd[7:0]}}; half {2{wd[15:0]}}; word wd.
  - Go to REQ.
- REQ:
  - bus_req=1; address, enables and data are held stable until bus_gnt.
  - On bus_gnt: a write goes to DONE; a read goes to WAIT.
  - bus_req=0 starting the cycle after the grant.
- WAIT:
  - bus_rvalid is legal no earlier than the cycle after the grant.
  - On bus_rvalid: read_data = bus_rdata >> (8*addr[1:0]), truncated to the access size, sign-extended unless funct3[2]=1. Go to DONE.
- DONE:
  - stall=0 for exactly one cycle, so the core commits and the PC advances on this edge.
  - The next state is always IDLE, even if act is still high; the next instruction then starts fresh.
  - read_data holds its value until the next capture.
- Latency (stall cycles with immediate grant): store 2; load with rvalid one cycle after the grant 3.
- bus_rvalid or bus_gnt outside REQ/WAIT is ignored.
- Reset mid-transaction: return to IDLE and drop bus_req on the reset edge. A late rvalid is ignored.
- access_fault and bus_err are high only in DONE.

Optional Feature:
- LSU_BUS_TIMEOUT_EN defined:
  - A saturating counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES without a grant/rvalid: drop bus_req, go to DONE, bus_err=1, read_data=0.
- Undefined: no counter. bus_err is tied to 0 and the LSU waits indefinitely.

Test Plan:
- Byte store to addr 0x103 with wd 0x000000A5, bus_gnt immediate -> bus_addr=0x40, bus_be=1000, bus_wdata=0xA5A5A5A5; stall high 2 cycles, then low 1.
- Signed half load at 0x102, bus_rdata=0x8001_1234 one cycle after grant -> read_data=0xFFFF8001. Same with funct3[2]=1 -> 0x00008001.
- Word load at 0x201 -> no bus_req; access_fault pulse; read_data=0; stall exactly 1 cycle.
- Word load with bus_gnt delayed 5 cycles and rvalid delayed 3 more -> bus_req held stable 6 cycles; read_data=bus_rdata; total stall 10 cycles.
- reset asserted in WAIT, then rvalid arrives -> state IDLE, read_data stays 0, no stall.
- With LSU_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=4, gnt never arrives -> bus_err pulse after 4 REQ cycles; read_data=0; core resumes.
